// File: rtl/mm_skew_feeder.sv
// Fetches operand lines from RAM and feeds them skewed into an N-lane systolic array.
// Build with MM_SKEW_FEEDER_STALL_CNT_EN defined to include the stall-cycle counter.
module mm_skew_feeder #(
  parameter int N  = 16,
  parameter int EW = 8,
  parameter int AW = 8,
  localparam int OW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [OW-1:0]     cmd_row_len,
  input  logic [OW-1:0]     cmd_col_len,
  input  logic [AW+OW-1:0]  cmd_start_addr,
  input  logic              cmd_mode,
  output logic              ram_rd_vld,
  output logic [AW-1:0]     ram_rd_addr,
  input  logic              ram_rdata_vld,
  input  logic [N*EW-1:0]   ram_rdata,
  output logic [N-1:0]      mxu_vld,
  output logic [N*EW-1:0]   mxu_data,
  input  logic              mxu_rdy,
  output logic              mxu_end,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, FEED} state_t;

  state_t              state;
  logic [OW-1:0]       row_len;
  logic [OW-1:0]       col_len;
  logic [OW-1:0]       offset;
  logic [OW-1:0]       req_cnt;
  logic                mode;
  logic [OW:0]         ret_cnt;
  logic [OW:0]         beat;
  logic [N*EW-1:0]     entry [N];
  logic [N*EW-1:0]     ents  [N];
  logic                ret_wr;
  logic                ret_done;
  logic [N-1:0]        nxt_vld;
  logic [N*EW-1:0]     nxt_data;
  logic                nxt_end;

  assign cmd_rdy  = (state == IDLE);
  assign ret_wr   = ram_rdata_vld && (state == LOAD || state == WAIT) &&
                    ({1'b0, row_len} >= ret_cnt);
  assign ret_done = ret_wr && (ret_cnt[OW-1:0] == row_len);

  always_ff @(posedge clk) begin
    if (ret_wr) entry[ret_cnt[OW-1:0]] <= ram_rdata;
  end

  // Forward the line being written this cycle so beat 0 can be built on FEED entry.
  always_comb begin
    ents = entry;
    if (ret_wr) ents[ret_cnt[OW-1:0]] = ram_rdata;
  end

  // Lane pattern for the beat about to be presented: beat 0 on FEED entry, else beat+1.
  always_comb begin : lanes
    int unsigned b;
    int unsigned rl;
    int unsigned cl;
    int unsigned k;
    int unsigned e;
    nxt_vld  = '0;
    nxt_data = '0;
    b        = (state == FEED) ? 32'(beat) + 32'd1 : 32'd0;
    rl       = 32'(row_len);
    cl       = 32'(col_len);
    nxt_end  = (b == rl + cl);
    for (int unsigned i = 0; i < N; i++) begin
      if (mode) begin
        nxt_vld[i] = (i <= rl) && (b >= i) && (b <= i + cl);
        k = i;
        e = 32'(offset) + b - i;
      end else begin
        nxt_vld[i] = (i <= cl) && (b >= i) && (b <= i + rl);
        k = b - i;
        e = 32'(offset) + i;
      end
      if (nxt_vld[i])
        nxt_data[i*EW +: EW] = EW'(ents[OW'(k)] >> (EW * (e % N)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_len     <= '0;
      col_len     <= '0;
      offset      <= '0;
      mode        <= 1'b0;
      req_cnt     <= '0;
      ret_cnt     <= '0;
      beat        <= '0;
      ram_rd_vld  <= 1'b0;
      ram_rd_addr <= '0;
      mxu_vld     <= '0;
      mxu_data    <= '0;
      mxu_end     <= 1'b0;
    end else begin
      if (ret_wr) ret_cnt <= ret_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (cmd_vld) begin
            row_len     <= cmd_row_len;
            col_len     <= cmd_col_len;
            offset      <= cmd_start_addr[OW-1:0];
            mode        <= cmd_mode;
            ram_rd_addr <= cmd_start_addr[AW+OW-1:OW];
            ram_rd_vld  <= 1'b1;
            req_cnt     <= '0;
            ret_cnt     <= '0;
            beat        <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (req_cnt == row_len) begin
            ram_rd_vld <= 1'b0;
            if (ret_done) begin
              state    <= FEED;
              mxu_vld  <= nxt_vld;
              mxu_data <= nxt_data;
              mxu_end  <= nxt_end;
            end else begin
              state <= WAIT;
            end
          end else begin
            req_cnt     <= req_cnt + 1'b1;
            ram_rd_addr <= ram_rd_addr + 1'b1;
          end
        end
        WAIT: begin
          if (ret_done) begin
            state    <= FEED;
            mxu_vld  <= nxt_vld;
            mxu_data <= nxt_data;
            mxu_end  <= nxt_end;
          end
        end
        FEED: begin
          if (mxu_rdy) begin
            if (mxu_end) begin
              state    <= IDLE;
              mxu_vld  <= '0;
              mxu_data <= '0;
              mxu_end  <= 1'b0;
            end else begin
              beat     <= beat + 1'b1;
              mxu_vld  <= nxt_vld;
              mxu_data <= nxt_data;
              mxu_end  <= nxt_end;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MM_SKEW_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_q <= '0;
    else if (state == IDLE && cmd_vld)
      stall_q <= '0;
    else if (state == FEED && !mxu_rdy && stall_q != '1)
      stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mm_skew_feeder.sv
// Scoreboard bench for mm_skew_feeder: expected beats and read addresses are queued per command.
module tb_mm_skew_feeder;
  localparam int N  = 16;
  localparam int EW = 8;
  localparam int AW = 8;
  localparam int OW = 4;
`ifdef MM_SKEW_FEEDER_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_vld = 1'b0;
  logic              cmd_rdy;
  logic [OW-1:0]     cmd_row_len = '0;
  logic [OW-1:0]     cmd_col_len = '0;
  logic [AW+OW-1:0]  cmd_start_addr = '0;
  logic              cmd_mode = 1'b0;
  logic              ram_rd_vld;
  logic [AW-1:0]     ram_rd_addr;
  logic              ram_rdata_vld = 1'b0;
  logic [N*EW-1:0]   ram_rdata = '0;
  logic [N-1:0]      mxu_vld;
  logic [N*EW-1:0]   mxu_data;
  logic              mxu_rdy = 1'b1;
  logic              mxu_end;
  logic [15:0]       stall_cnt;

  mm_skew_feeder #(.N(N), .EW(EW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_row_len(cmd_row_len),
    .cmd_col_len(cmd_col_len), .cmd_start_addr(cmd_start_addr), .cmd_mode(cmd_mode),
    .ram_rd_vld(ram_rd_vld), .ram_rd_addr(ram_rd_addr),
    .ram_rdata_vld(ram_rdata_vld), .ram_rdata(ram_rdata),
    .mxu_vld(mxu_vld), .mxu_data(mxu_data), .mxu_rdy(mxu_rdy),
    .mxu_end(mxu_end), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]    vld;
    logic [N*EW-1:0] data;
    logic            last;
  } beat_t;

  typedef struct {
    int unsigned   due;
    logic [AW-1:0] addr;
  } req_t;

  beat_t         exp_q[$];
  logic [AW-1:0] rd_exp_q[$];
  logic [AW-1:0] rd_seen_q[$];
  req_t          pend_q[$];
  int unsigned   cyc = 0;
  int unsigned   lat = 1;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [EW-1:0] elem(input int ln, input int e);
    return 8'(((ln & 255) * 31) + (e * 5) + 3);
  endfunction

  function automatic logic [N*EW-1:0] line_of(input logic [AW-1:0] a);
    logic [N*EW-1:0] v;
    v = '0;
    for (int e = 0; e < N; e++) v[e*EW +: EW] = elem(int'(a), e);
    return v;
  endfunction

  // RAM model: fixed latency `lat`, returns in request order.
  always @(posedge clk) begin
    cyc++;
    if (ram_rd_vld) begin
      pend_q.push_back('{due: cyc + lat - 1, addr: ram_rd_addr});
      rd_seen_q.push_back(ram_rd_addr);
    end
  end

  always @(negedge clk) begin
    req_t r;
    ram_rdata_vld = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      r = pend_q.pop_front();
      ram_rdata_vld = 1'b1;
      ram_rdata = line_of(r.addr);
    end
  end

  task automatic check(input string tag, input logic [N*EW-1:0] obs, input logic [N*EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cmd(input int rl, input int cl, input int sa, input logic mode);
    int    ln;
    int    off;
    beat_t bt;
    ln  = (sa >> 4) & 255;
    off = sa & 15;
    for (int k = 0; k <= rl; k++) rd_exp_q.push_back(8'((ln + k) & 255));
    for (int c = 0; c <= rl + cl; c++) begin
      bt.vld  = '0;
      bt.data = '0;
      bt.last = (c == rl + cl);
      for (int i = 0; i < N; i++) begin
        int r;
        int el;
        bit ok;
        if (mode) begin
          ok = (i <= rl) && (c - i >= 0) && (c - i <= cl);
          r  = i;
          el = (off + c - i) & 15;
        end else begin
          ok = (i <= cl) && (c - i >= 0) && (c - i <= rl);
          r  = c - i;
          el = (off + i) & 15;
        end
        if (ok) begin
          bt.vld[i] = 1'b1;
          bt.data[i*EW +: EW] = elem(ln + r, el);
        end
      end
      exp_q.push_back(bt);
    end
  endtask

  task automatic send_cmd(input int rl, input int cl, input int sa, input logic mode);
    int budget;
    budget = 0;
    while (!cmd_rdy && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("cmd_rdy_idle", cmd_rdy, 1'b1);
    expect_cmd(rl, cl, sa, mode);
    cmd_vld        = 1'b1;
    cmd_row_len    = 4'(rl);
    cmd_col_len    = 4'(cl);
    cmd_start_addr = 12'(sa);
    cmd_mode       = mode;
    @(negedge clk);
    cmd_vld        = 1'b0;
    cmd_row_len    = 4'($urandom);
    cmd_col_len    = 4'($urandom);
    cmd_start_addr = 12'($urandom);
    cmd_mode       = ~mode;
    check("cmd_rdy_busy", cmd_rdy, 1'b0);
  endtask

  task automatic run_feed(input int stall_at, input int stall_len);
    int    done;
    int    left;
    int    budget;
    beat_t e;
    done = 0;
    left = stall_len;
    budget = 0;
    while (exp_q.size() > 0 && budget < 500) begin
      if (mxu_vld != '0) begin
        if (done == stall_at && left > 0) begin
          e = exp_q[0];
          mxu_rdy = 1'b0;
          check("hold_vld", mxu_vld, e.vld);
          check("hold_data", mxu_data, e.data);
          left--;
        end else begin
          e = exp_q.pop_front();
          mxu_rdy = 1'b1;
          check("beat_vld", mxu_vld, e.vld);
          check("beat_data", mxu_data, e.data);
          check("beat_end", mxu_end, e.last);
          done++;
        end
      end else begin
        mxu_rdy = 1'b1;
      end
      @(negedge clk);
      budget++;
    end
    mxu_rdy = 1'b1;
    check("feed_beats_left", exp_q.size(), 0);
    exp_q.delete();
    check("post_cmd_rdy", cmd_rdy, 1'b1);
    check("post_mxu_vld", mxu_vld, '0);
    check("post_mxu_end", mxu_end, 1'b0);
  endtask

  task automatic check_reads();
    check("rd_count", rd_seen_q.size(), rd_exp_q.size());
    for (int i = 0; i < rd_seen_q.size() && i < rd_exp_q.size(); i++)
      check("rd_addr", rd_seen_q[i], rd_exp_q[i]);
    rd_seen_q.delete();
    rd_exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_rdy"}, cmd_rdy, 1'b1);
    check({tag, "_rd_vld"}, ram_rd_vld, 1'b0);
    check({tag, "_mxu_vld"}, mxu_vld, '0);
    check({tag, "_mxu_data"}, mxu_data, '0);
    check({tag, "_mxu_end"}, mxu_end, 1'b0);
  endtask

  initial begin
    int budget;
    // reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("reset");
    check("reset_rd_addr", ram_rd_addr, '0);
    check("reset_stall", stall_cnt, '0);

    // row-fed 4x4, 1-cycle RAM
    lat = 1;
    send_cmd(3, 3, 'h120, 1'b1);
    run_feed(-1, 0);
    check_reads();
    check("stall_none", stall_cnt, '0);

    // column-fed 4x4 with offset 5
    send_cmd(3, 3, 'h125, 1'b0);
    run_feed(-1, 0);
    check_reads();

    // 4-cycle stall at beat 2
    send_cmd(3, 3, 'h120, 1'b1);
    run_feed(2, 4);
    check_reads();
    check("stall_cnt4", stall_cnt, STALL_EN ? 16'd4 : 16'd0);

    // element offset wraps modulo N
    send_cmd(1, 3, 'h34E, 1'b1);
    run_feed(-1, 0);
    check_reads();

    // line address wraps modulo 2^AW
    lat = 2;
    send_cmd(3, 2, 'hFE7, 1'b1);
    run_feed(-1, 0);
    check_reads();

    // full-size column-fed with a short stall; counter restarts per command
    send_cmd(15, 15, 'h3A9, 1'b0);
    run_feed(20, 2);
    check_reads();
    check("stall_cnt2", stall_cnt, STALL_EN ? 16'd2 : 16'd0);

    // reset while waiting for returns; late returns must be dropped
    lat = 3;
    send_cmd(1, 1, 'h200, 1'b1);
    budget = 0;
    while (ram_rd_vld && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("wait_reached", ram_rd_vld, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("midreset");
    check("midreset_rd_addr", ram_rd_addr, '0);
    check("midreset_stall", stall_cnt, '0);
    repeat (5) begin
      @(negedge clk);
      check("late_ret_mxu_vld", mxu_vld, '0);
      check("late_ret_cmd_rdy", cmd_rdy, 1'b1);
    end
    check("abandoned_reads", rd_seen_q.size(), 2);
    exp_q.delete();
    rd_exp_q.delete();
    rd_seen_q.delete();
    send_cmd(2, 1, 'h201, 1'b0);
    run_feed(-1, 0);
    check_reads();

    // 1x1 command, 3-cycle RAM
    send_cmd(0, 0, 'h055, 1'b1);
    run_feed(-1, 0);
    check_reads();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
